// File: rtl/cpu_pkg.sv
// cpu_pkg: shared next-PC op encodings, fetch PC FSM states and default vectors
package cpu_pkg;
  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;
  localparam logic [2:0] NPC_J    = 3'b100;
  localparam logic [2:0] NPC_ERET = 3'b101;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
  typedef enum logic {RUN, PEND} pc_state_e;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect decode and target address computation
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [2:0]        npc_op_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] redir_pc4_i,
  input  logic [15:0]       imm16_i,
  input  logic [25:0]       idx26_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              redirect_o
);
  logic [ADDR_W-1:0] br_off;
  // word offset sign-extended to the full PC width
  always_comb br_off = {{(ADDR_W-18){imm16_i[15]}}, imm16_i, 2'b00};
  // select target by op; ops 110/111 are sequential and never redirect
  always_comb begin
    target_o = (npc_op_i == NPC_BR) ? redir_pc4_i + br_off :
               (npc_op_i == NPC_JAL || npc_op_i == NPC_J) ? {redir_pc4_i[ADDR_W-1:28], idx26_i, 2'b00} :
               (npc_op_i == NPC_ERET) ? epc_i : rs_i;
    redirect_o = (npc_op_i == NPC_BR && br_taken_i) || npc_op_i inside {NPC_JAL, NPC_JR, NPC_J, NPC_ERET};
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with stall hold, pending-redirect buffer, exception entry and eret.
// Optional PC_GEN_ALIGN_CHECK_EN: misaligned redirect targets raise an alignment exception.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic [2:0]        npc_op_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] redir_pc4_i,
  input  logic [15:0]       imm16_i,
  input  logic [25:0]       idx26_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic              exc_req_i,
  input  logic [ADDR_W-1:0] exc_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              pend_o
`ifdef PC_GEN_ALIGN_CHECK_EN
  ,
  output logic              align_exc_o
`endif
);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VEC);
  pc_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, tgt_q, tgt_d, target, load_tgt;
  logic redirect, load;
`ifdef PC_GEN_ALIGN_CHECK_EN
  logic align_q, align_d;
  assign align_exc_o = align_q;
`endif
  pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .npc_op_i   (npc_op_i),
    .br_taken_i (br_taken_i),
    .redir_pc4_i(redir_pc4_i),
    .imm16_i    (imm16_i),
    .idx26_i    (idx26_i),
    .rs_i       (rs_i),
    .epc_i      (epc_q),
    .target_o   (target),
    .redirect_o (redirect)
  );
  assign pc_o   = pc_q;
  assign pc4_o  = pc_q + ADDR_W'(4);
  assign epc_o  = epc_q;
  assign pend_o = (state_q == PEND);
  // next-state: exception > pending release > redirect > capture under stall > sequential > hold
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    tgt_d    = tgt_q;
`ifdef PC_GEN_ALIGN_CHECK_EN
    align_d  = 1'b0;
`endif
    load     = !stall_i && (state_q == PEND || redirect);
    load_tgt = (state_q == PEND) ? tgt_q : target;
    if (exc_req_i) begin
      pc_d    = EXC_PC;
      epc_d   = exc_pc_i;
      tgt_d   = '0;
      state_d = RUN;
    end else if (load) begin
      state_d = RUN;
      pc_d    = load_tgt;
`ifdef PC_GEN_ALIGN_CHECK_EN
      if (load_tgt[1:0] != 2'b00) begin
        pc_d    = EXC_PC;
        epc_d   = load_tgt;
        align_d = 1'b1;
      end
`endif
    end else if (redirect && state_q == RUN) begin
      tgt_d   = target;
      state_d = PEND;
    end else if (!stall_i) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end
  // architectural state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RST_PC;
      epc_q   <= '0;
      tgt_q   <= '0;
`ifdef PC_GEN_ALIGN_CHECK_EN
      align_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      tgt_q   <= tgt_d;
`ifdef PC_GEN_ALIGN_CHECK_EN
      align_q <= align_d;
`endif
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen (align checks when PC_GEN_ALIGN_CHECK_EN is defined)
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst_n, stall_i, br_taken_i, exc_req_i, pend_o;
  logic [2:0]  npc_op_i;
  logic [31:0] redir_pc4_i, rs_i, exc_pc_i, pc_o, pc4_o, epc_o;
  logic [15:0] imm16_i;
  logic [25:0] idx26_i;
`ifdef PC_GEN_ALIGN_CHECK_EN
  logic        align_exc_o;
`endif
  int n_chk = 0;
  int n_fail = 0;

  pc_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .npc_op_i   (npc_op_i),
    .br_taken_i (br_taken_i),
    .redir_pc4_i(redir_pc4_i),
    .imm16_i    (imm16_i),
    .idx26_i    (idx26_i),
    .rs_i       (rs_i),
    .exc_req_i  (exc_req_i),
    .exc_pc_i   (exc_pc_i),
    .pc_o       (pc_o),
    .pc4_o      (pc4_o),
    .epc_o      (epc_o),
    .pend_o     (pend_o)
`ifdef PC_GEN_ALIGN_CHECK_EN
    ,
    .align_exc_o(align_exc_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; npc_op_i = 3'b000; br_taken_i = 1'b0;
    redir_pc4_i = '0; imm16_i = '0; idx26_i = '0; rs_i = '0; exc_req_i = 1'b0; exc_pc_i = '0;
    repeat (2) tick();
    chk("rst_pc", pc_o, 32'h3000);
    chk("rst_pc4", pc4_o, 32'h3004);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_pend", 32'(pend_o), 32'h0);
    rst_n = 1'b1;
    tick(); chk("seq1", pc_o, 32'h3004);
    tick(); chk("seq2", pc_o, 32'h3008);
    tick(); chk("seq3", pc_o, 32'h300C);
    tick(); chk("seq4", pc_o, 32'h3010);
    npc_op_i = 3'b001; br_taken_i = 1'b0; redir_pc4_i = 32'h3010; imm16_i = 16'hFFFC;
    tick(); chk("br_not_taken", pc_o, 32'h3014);
    br_taken_i = 1'b1;
    tick(); chk("br_taken", pc_o, 32'h3000);
    npc_op_i = 3'b000; br_taken_i = 1'b0; stall_i = 1'b1;
    tick(); chk("stall_hold", pc_o, 32'h3000);
    npc_op_i = 3'b011; rs_i = 32'h5000;
    tick(); chk("pend_hold1", pc_o, 32'h3000); chk("pend1", 32'(pend_o), 32'h1);
    tick(); chk("pend_hold2", pc_o, 32'h3000); chk("pend2", 32'(pend_o), 32'h1);
    npc_op_i = 3'b000; stall_i = 1'b0;
    tick(); chk("pend_release", pc_o, 32'h5000); chk("pend_clr", 32'(pend_o), 32'h0);
    chk("pc4_after", pc4_o, 32'h5004);
    stall_i = 1'b1; npc_op_i = 3'b011; rs_i = 32'h6000;
    tick(); chk("first_wins_pend", 32'(pend_o), 32'h1);
    rs_i = 32'h7000;
    tick(); chk("first_wins_hold", pc_o, 32'h5000);
    stall_i = 1'b0; npc_op_i = 3'b000;
    tick(); chk("first_wins", pc_o, 32'h6000);
    stall_i = 1'b1; npc_op_i = 3'b010; redir_pc4_i = 32'h3010; idx26_i = 26'h0000C08;
    tick(); chk("jal_pend", 32'(pend_o), 32'h1);
    npc_op_i = 3'b000; exc_req_i = 1'b1; exc_pc_i = 32'h3020;
    tick();
    chk("exc_pc", pc_o, 32'h4180); chk("exc_epc", epc_o, 32'h3020); chk("exc_pend", 32'(pend_o), 32'h0);
    exc_req_i = 1'b0; stall_i = 1'b0;
    tick(); chk("exc_seq", pc_o, 32'h4184);
    npc_op_i = 3'b101;
    tick(); chk("eret", pc_o, 32'h3020);
    npc_op_i = 3'b010;
    tick(); chk("jal", pc_o, 32'h3020);
    npc_op_i = 3'b100; redir_pc4_i = 32'hA000_0010; idx26_i = 26'h3FF_FFFF;
    tick(); chk("j_upper", pc_o, 32'hAFFF_FFFC);
    npc_op_i = 3'b011; rs_i = 32'hFFFF_FFFC;
    tick(); chk("jr_top", pc_o, 32'hFFFF_FFFC);
    npc_op_i = 3'b110;
    tick(); chk("wrap_op6", pc_o, 32'h0);
    npc_op_i = 3'b101; exc_req_i = 1'b1; exc_pc_i = 32'h1234;
    tick(); chk("exc_eret_pc", pc_o, 32'h4180); chk("exc_eret_epc", epc_o, 32'h1234);
    exc_req_i = 1'b0;
    tick(); chk("eret2", pc_o, 32'h1234);
    npc_op_i = 3'b011; rs_i = 32'h5002;
`ifdef PC_GEN_ALIGN_CHECK_EN
    tick();
    chk("align_pc", pc_o, 32'h4180); chk("align_epc", epc_o, 32'h5002);
    chk("align_hi", 32'(align_exc_o), 32'h1);
    npc_op_i = 3'b000;
    tick(); chk("align_lo", 32'(align_exc_o), 32'h0); chk("align_seq", pc_o, 32'h4184);
`else
    tick(); chk("misalign_load", pc_o, 32'h5002);
    npc_op_i = 3'b000;
`endif
    stall_i = 1'b1; npc_op_i = 3'b011; rs_i = 32'h5000;
    tick(); chk("pre_rst_pend", 32'(pend_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc_o, 32'h3000); chk("async_rst_pend", 32'(pend_o), 32'h0);
    chk("async_rst_epc", epc_o, 32'h0);
    tick(); rst_n = 1'b1; stall_i = 1'b0; npc_op_i = 3'b000;
    tick(); chk("post_rst_seq", pc_o, 32'h3004);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Next-generation fetch PC unit: holds the architectural fetch PC register and selects the next PC each cycle.
- Replaces the purely combinational next-PC selector. Adds:
  - parametrised address width and vectors
  - stall hold
  - a pending-redirect buffer for redirects that arrive while fetch is stalled
  - exception entry and eret with an internal EPC register
- Sits between the hazard unit and decode stage (which supply control) and the instruction memory (which consumes pc_o).

Parameters:
- ADDR_W, 32, PC width in bits; must be >= 30.
- RESET_VEC, 32'h0000_3000, PC loaded on reset; truncated to ADDR_W.
- EXC_VEC, 32'h0000_4180, exception handler entry PC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_i  in  1  hold PC; fetch not advancing.
- npc_op_i  in  3  op from decode: 000 seq, 001 branch, 010 jal, 011 jr, 100 j, 101 eret; 110/111 treated as seq.
- br_taken_i  in  1  branch condition result; qualifies op 001.
- redir_pc4_i  in  ADDR_W  PC+4 of the instruction in decode.
- imm16_i  in  16  branch offset field.
- idx26_i  in  26  jump index field.
- rs_i  in  ADDR_W  forwarded rs value for jr.
- exc_req_i  in  1  exception taken this cycle.
- exc_pc_i  in  ADDR_W  PC to save into EPC.
- pc_o  out  ADDR_W  current fetch PC.
- pc4_o  out  ADDR_W  pc_o + 4.
- epc_o  out  ADDR_W  saved EPC.
- pend_o  out  1  redirect buffered, waiting for stall release.

Behaviour:
- Reset (async, rst_n low):
  - pc_o = RESET_VEC, epc_o = 0, pend_o = 0, state = RUN, pending target = 0.
  - Deassertion is sampled synchronously; the first edge after release follows normal rules.
- Target arithmetic, all modulo 2^ADDR_W:
  - branch: redir_pc4_i + (sign-extended imm16_i << 2)
  - j/jal: {redir_pc4_i[ADDR_W-1:28], idx26_i, 2'b00}
  - jr: rs_i
  - eret: epc_o
- redirect = (op==001 && br_taken_i) || op in {010, 011, 100, 101}.
  - op 001 with br_taken_i=0 is seq.
- Priority per edge, highest first:
  1. exc_req_i: pc <= EXC_VEC, epc <= exc_pc_i, pending cleared, state RUN. Overrides stall.
  2. state PEND and !stall_i: pc <= pending target, state RUN.
  3. redirect and !stall_i: pc <= target.
  4. redirect and stall_i in state RUN: capture target, state PEND, pc holds.
  5. !stall_i: pc <= pc + 4.
  6. Otherwise pc holds.
- FSM states: RUN, PEND.
  - RUN->PEND on item 4.
  - PEND->RUN on item 2 or on an exception.
  - In PEND, new redirect requests are ignored; the first captured target wins. Decode is stalled, so it re-presents the same instruction.
- pend_o = (state == PEND), registered.
- pc4_o is combinational from pc_o. Latency: a redirect presented in cycle N appears on pc_o in cycle N+1 (unstalled).
- Wrap: pc 0xFFFF_FFFC + 4 -> 0x0000_0000; no flag.
- exc_req_i together with op 101 in the same cycle: exception wins and EPC is overwritten.
- eret reads epc_o as registered before the edge.

Optional Feature:
- Macro: PC_GEN_ALIGN_CHECK_EN
- Defined:
  - Adds output align_exc_o (1 bit, registered, reset 0).
  - A redirect target with bits [1:0] != 0 is not loaded. Instead pc <= EXC_VEC, epc <= the misaligned target, align_exc_o pulses high for one cycle.
  - An external exc_req_i in the same cycle still takes priority.
- Not defined: no port; targets load unmodified.

Decomposition:
- Shared package cpu_pkg:
  - npc_op encoding localparams: NPC_SEQ, NPC_BR, NPC_JAL, NPC_JR, NPC_J, NPC_ERET
  - pc_state enum {RUN, PEND}
  - default RESET_VEC and EXC_VEC constants
- One sub-module is natural: pc_target_calc, a combinational target and redirect decode. It is reusable by a later branch-predictor check.

Test Plan:
- Release rst_n, no stall, op seq for 3 cycles -> pc_o 0x3000, 0x3004, 0x3008, 0x300C.
- At pc 0x3010: op 001, br_taken_i=1, redir_pc4_i=0x3010, imm16_i=0xFFFC -> next pc_o = 0x3000. Same with br_taken_i=0 -> 0x3014.
- stall_i=1 with op 011, rs_i=0x0000_5000 for 2 cycles, then stall_i=0 -> pc holds and pend_o=1 during the stall. Next edge after release: pc_o = 0x5000, pend_o = 0.
- exc_req_i=1, exc_pc_i=0x3020, while stall_i=1 and PEND -> pc_o = 0x4180, epc_o = 0x3020, pend_o = 0. Later op 101 -> pc_o = 0x3020.
- Assert rst_n low mid-cycle while in PEND -> pc_o = 0x3000 and pend_o = 0 immediately, without waiting for clk.
- With PC_GEN_ALIGN_CHECK_EN: op 011, rs_i=0x5002 -> pc_o = 0x4180, epc_o = 0x5002, align_exc_o high for exactly one cycle.
